mtxmul_sequencer: RTL and testbench

MTXMUL_SEQUENCER -- requirements
Module: mtxmul_sequencer

---
 rtl/mtxmul_if.sv | 29 ++
 rtl/mtxmul_sequencer.sv | 112 +++++++++++
 tb/tb_mtxmul_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mtxmul_if.sv
// Handshake and result bus between the 8x8 matmul sequencer, the operand store/dot-product
// datapath (master side) and the result memory.
interface mtxmul_if;
    logic        start;
    logic        abort;
    logic        opnd_ready;
    logic [2:0]  row_sel;
    logic [2:0]  col_sel;
    logic [5:0]  dest_i;
    logic        issue;
    logic [31:0] dot_product;
    logic [5:0]  dest_o;
    logic        res_we;
    logic [5:0]  res_addr;
    logic [31:0] res_data;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, abort, opnd_ready, dot_product, dest_o,
        input  row_sel, col_sel, dest_i, issue, res_we, res_addr, res_data, busy, done, err
    );

    modport slave (
        input  start, abort, opnd_ready, dot_product, dest_o,
        output row_sel, col_sel, dest_i, issue, res_we, res_addr, res_data, busy, done, err
    );
endinterface

// File: rtl/mtxmul_sequencer.sv
// Issue/writeback sequencer for an 8x8 matrix product on a fixed-latency dot-product pipeline.
//   state | meaning
//   IDLE  | waiting for START
//   ISSUE | issuing operand pairs 0..63 whenever the operand store is ready
//   DRAIN | all issued, waiting for the remaining results to be written
//   FIN   | one-cycle DONE pulse
module mtxmul_sequencer #(
    parameter int LATENCY = 3
) (
    input logic     ACLK,
    input logic     ARESETN,
    mtxmul_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t             state_q, state_d;
    logic [5:0]         issue_cnt_q, issue_cnt_d;
    logic [5:0]         wr_cnt_q, wr_cnt_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] vld_shift;
    logic               err_q, err_d;
    logic               issue;
    logic               vld_out;

    assign issue   = (state_q == S_ISSUE) && bus.opnd_ready;
    assign vld_out = vld_q[LATENCY-1];

    // Valid bits travel alongside the datapath so bubbles never produce a write.
    generate
        if (LATENCY == 1) begin : g_lat1
            assign vld_shift = issue;
        end else begin : g_latn
            assign vld_shift = {vld_q[LATENCY-2:0], issue};
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        vld_d       = vld_shift;
        err_d       = err_q;

        if (vld_out) begin
            wr_cnt_d = wr_cnt_q + 6'd1;
            if (bus.dest_o != wr_cnt_q) err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    issue_cnt_d = '0;
                    wr_cnt_d    = '0;
                    err_d       = 1'b0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 6'd1;
                    if (issue_cnt_q == 6'd63) state_d = S_DRAIN;
                end
                if (bus.abort) begin
                    state_d = S_IDLE;
                    vld_d   = '0;
                end
            end
            S_DRAIN: begin
                if (vld_out && (wr_cnt_q == 6'd63)) state_d = S_FIN;
                if (bus.abort) begin
                    state_d = S_IDLE;
                    vld_d   = '0;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            wr_cnt_q    <= '0;
            vld_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            vld_q       <= vld_d;
            err_q       <= err_d;
        end
    end

    assign bus.issue    = issue;
    assign bus.row_sel  = issue_cnt_q[5:3];
    assign bus.col_sel  = issue_cnt_q[2:0];
    assign bus.dest_i   = issue_cnt_q;
    assign bus.res_we   = vld_out;
    assign bus.res_addr = vld_out ? bus.dest_o : 6'd0;
    assign bus.res_data = vld_out ? bus.dot_product : 32'd0;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_FIN);
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mtxmul_sequencer.sv
// Bench for mtxmul_sequencer: table of whole runs checked against a cycle-level issue/write
// schedule model, plus hand-written abort, restart-while-busy and mid-run reset sequences.
module tb_mtxmul_sequencer;
    localparam int LAT  = 3;
    localparam int MAXC = 400;
    localparam int M_ALL = 0, M_ALT = 1, M_RND = 2;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    mtxmul_if bus ();

    mtxmul_sequencer #(.LATENCY(LAT)) dut (
        .ACLK   (ACLK),
        .ARESETN(ARESETN),
        .bus    (bus)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    function automatic logic [31:0] fdata(input logic [5:0] x);
        return {26'd0, x} * 32'h9E3779B1 + 32'h01234567;
    endfunction

    // Dot-product datapath stand-in: fixed LAT-cycle delay of the issued index.
    logic [5:0] pd [LAT];
    logic       inj = 1'b0;
    always @(posedge ACLK) begin
        pd[0] <= bus.dest_i;
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
    assign bus.dest_o      = (inj && pd[LAT-1] == 6'd4) ? 6'd5 : pd[LAT-1];
    assign bus.dot_product = fdata(pd[LAT-1]);

    // Observed events, recorded on the falling edge.
    bit mon_en = 1'b0;
    int w_addr[$], w_data[$], w_cyc[$], i_dest[$], i_cyc[$], d_cyc[$];
    always @(negedge ACLK) begin
        if (mon_en) begin
            if (bus.res_we) begin
                w_addr.push_back(int'(bus.res_addr));
                w_data.push_back(int'(bus.res_data));
                w_cyc.push_back(cyc);
            end
            if (bus.issue) begin
                i_dest.push_back(int'(bus.dest_i));
                i_cyc.push_back(cyc);
            end
            if (bus.done) d_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        w_addr.delete(); w_data.delete(); w_cyc.delete();
        i_dest.delete(); i_cyc.delete(); d_cyc.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " busy"},     32'(bus.busy),     0);
        chk({tag, " done"},     32'(bus.done),     0);
        chk({tag, " issue"},    32'(bus.issue),    0);
        chk({tag, " res_we"},   32'(bus.res_we),   0);
        chk({tag, " row_sel"},  32'(bus.row_sel),  0);
        chk({tag, " col_sel"},  32'(bus.col_sel),  0);
        chk({tag, " dest_i"},   32'(bus.dest_i),   0);
        chk({tag, " res_addr"}, 32'(bus.res_addr), 0);
        chk({tag, " res_data"}, bus.res_data,      0);
        chk({tag, " err"},      32'(bus.err),      0);
    endtask

    // One full run. The model: issues land on the ready cycles (relative to START in cycle 0,
    // first possible issue in cycle 1) until 64 are taken; each write follows its issue by LAT;
    // DONE follows the last write by one cycle.
    task automatic run_case(input string tag, input int mode, input bit inject, input bit poke,
                            input int exp_done_in, input bit exp_err);
        bit rdy[MAXC];
        int exp_i[$];
        int k, t0, exp_done;
        bit timed_out;
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                M_ALL:   rdy[c] = 1'b1;
                M_ALT:   rdy[c] = (c % 2) == 1;
                default: rdy[c] = ($urandom_range(0, 3) != 0);
            endcase
        end
        k = 0;
        for (int c = 1; c < MAXC; c++) begin
            if (rdy[c] && k < 64) begin
                exp_i.push_back(c);
                k++;
            end
        end
        exp_done = exp_done_in;
        if (exp_done < 0) exp_done = (exp_i.size() == 64) ? exp_i[63] + LAT + 1 : MAXC + 10;

        clear_mon();
        inj = inject;
        @(posedge ACLK); #1;
        bus.start = 1'b1;
        bus.opnd_ready = rdy[0];
        t0 = cyc;
        mon_en = 1'b1;
        timed_out = 1'b1;
        for (int c = 1; c < MAXC; c++) begin
            @(posedge ACLK); #1;
            bus.opnd_ready = rdy[c];
            bus.start = poke && (c == exp_done);
            bus.abort = poke && (c == exp_done);
            if (c == 1) begin
                @(negedge ACLK);
                chk({tag, " err cleared by start"}, 32'(bus.err), 0);
                chk({tag, " busy after start"}, 32'(bus.busy), 1);
            end
            if (d_cyc.size() > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.opnd_ready = 1'b0;
        chk({tag, " timeout"}, 32'(timed_out), 0);
        repeat (4) @(posedge ACLK);
        @(negedge ACLK);
        mon_en = 1'b0;

        chk({tag, " write count"}, 32'(w_addr.size()), 64);
        for (int i = 0; i < w_addr.size() && i < 64; i++) begin
            chk($sformatf("%s write%0d addr", tag, i), 32'(w_addr[i]), (inject && i == 4) ? 5 : i);
            chk($sformatf("%s write%0d data", tag, i), 32'(w_data[i]), fdata(6'(i)));
            if (i < exp_i.size())
                chk($sformatf("%s write%0d cycle", tag, i), 32'(w_cyc[i] - t0), 32'(exp_i[i] + LAT));
        end
        chk({tag, " issue count"}, 32'(i_dest.size()), 64);
        for (int i = 0; i < i_dest.size() && i < exp_i.size(); i++) begin
            chk($sformatf("%s issue%0d index", tag, i), 32'(i_dest[i]), 32'(i));
            chk($sformatf("%s issue%0d cycle", tag, i), 32'(i_cyc[i] - t0), 32'(exp_i[i]));
        end
        chk({tag, " done count"}, 32'(d_cyc.size()), 1);
        if (d_cyc.size() > 0) chk({tag, " done cycle"}, 32'(d_cyc[0] - t0), 32'(exp_done));
        chk({tag, " err final"}, 32'(bus.err), 32'(exp_err));
        chk({tag, " busy final"}, 32'(bus.busy), 0);
    endtask

    typedef struct {
        string name;
        int    mode;
        bit    inject;
        bit    poke;
        int    exp_done;
        bit    exp_err;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int t0, late_w;
        tbl[0] = '{"full_rate",   M_ALL, 1'b0, 1'b0, 68,  1'b0};
        tbl[1] = '{"alternate",   M_ALT, 1'b0, 1'b0, 131, 1'b0};
        tbl[2] = '{"bad_dest",    M_ALL, 1'b1, 1'b0, 68,  1'b1};
        tbl[3] = '{"after_err",   M_ALL, 1'b0, 1'b0, 68,  1'b0};
        tbl[4] = '{"fin_poke",    M_ALL, 1'b0, 1'b1, 68,  1'b0};
        tbl[5] = '{"random_a",    M_RND, 1'b0, 1'b0, -1,  1'b0};
        tbl[6] = '{"random_b",    M_RND, 1'b0, 1'b1, -1,  1'b0};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.opnd_ready = 1'b1;
        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check_all_zero("reset");
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        bus.opnd_ready = 1'b0;
        repeat (2) @(posedge ACLK);

        for (int v = 0; v < 7; v++)
            run_case(tbl[v].name, tbl[v].mode, tbl[v].inject, tbl[v].poke, tbl[v].exp_done, tbl[v].exp_err);

        // Abort after 20 issues: writes may still land in the abort cycle, never after.
        clear_mon();
        inj = 1'b0;
        @(posedge ACLK); #1;
        bus.start = 1'b1;
        bus.opnd_ready = 1'b1;
        t0 = cyc;
        mon_en = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge ACLK); #1;
            bus.start = 1'b0;
            bus.opnd_ready = (c != 21);
            bus.abort = (c == 21);
            if (c == 22) begin
                @(negedge ACLK);
                chk("abort busy next cycle", 32'(bus.busy), 0);
            end
        end
        bus.opnd_ready = 1'b0;
        @(negedge ACLK);
        mon_en = 1'b0;
        late_w = 0;
        foreach (w_cyc[i]) if (w_cyc[i] - t0 > 21) late_w++;
        chk("abort issue count", 32'(i_dest.size()), 20);
        chk("abort write count", 32'(w_addr.size()), 18);
        chk("abort late writes", 32'(late_w), 0);
        chk("abort done count", 32'(d_cyc.size()), 0);
        run_case("post_abort", M_ALL, 1'b0, 1'b0, 68, 1'b0);

        // START while busy is ignored, then reset mid-run at cycle 30.
        clear_mon();
        @(posedge ACLK); #1;
        bus.start = 1'b1;
        bus.opnd_ready = 1'b1;
        t0 = cyc;
        mon_en = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(posedge ACLK); #1;
            bus.start = (c == 10);
            ARESETN = !(c == 30);
            if (c == 12) begin
                @(negedge ACLK);
                chk("restart ignored dest_i", 32'(bus.dest_i), 11);
                chk("restart ignored row_sel", 32'(bus.row_sel), 1);
                chk("restart ignored col_sel", 32'(bus.col_sel), 3);
            end
            if (c == 30) begin
                @(negedge ACLK);
                check_all_zero("midrun reset");
            end
        end
        bus.opnd_ready = 1'b0;
        @(negedge ACLK);
        mon_en = 1'b0;
        chk("midrun reset done count", 32'(d_cyc.size()), 0);
        chk("midrun reset busy after", 32'(bus.busy), 0);
        run_case("post_reset", M_ALL, 1'b0, 1'b0, 68, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
